// File: rtl/fu_wb_arbiter.sv
// Writeback/CDB arbiter: per-unit result FIFOs feed up to CDB_W broadcast ports
// each cycle under round-robin arbitration, with back-pressure and flush squash.
module fu_wb_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int CDB_W     = 2,
  parameter int BUF_DEPTH = 2,
  parameter int DATA_W    = 64,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic [NUM_FU-1:0]           fu_vld_i,
  input  logic [NUM_FU-1:0]           fu_wr_i,
  input  logic [NUM_FU*PRF_IDX_W-1:0] fu_tag_i,
  input  logic [NUM_FU*DATA_W-1:0]    fu_value_i,
  input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx_i,
  output logic [NUM_FU-1:0]           fu_rdy_o,
  output logic [CDB_W-1:0]            cdb_vld_o,
  output logic [CDB_W-1:0]            cdb_wr_o,
  output logic [CDB_W*PRF_IDX_W-1:0]  cdb_tag_o,
  output logic [CDB_W*DATA_W-1:0]     cdb_value_o,
  output logic [CDB_W*ROB_IDX_W-1:0]  cdb_rob_idx_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int RR_W  = $clog2(NUM_FU);

  typedef struct packed {
    logic                 wr;
    logic [PRF_IDX_W-1:0] tag;
    logic [DATA_W-1:0]    value;
    logic [ROB_IDX_W-1:0] rob_idx;
  } entry_t;

  entry_t             buf_q  [NUM_FU][BUF_DEPTH];
  logic [PTR_W-1:0]   head_q [NUM_FU];
  logic [PTR_W-1:0]   tail_q [NUM_FU];
  logic [CNT_W-1:0]   cnt_q  [NUM_FU];
  logic [RR_W-1:0]    rr_q, rr_d;

  entry_t             in_ent [NUM_FU];
  entry_t             cand   [NUM_FU];
  logic [NUM_FU-1:0]  rdy, nonempty, accept, req, gnt, push, pop;
  logic [NUM_FU-1:0]  port_oh [CDB_W];

  logic [CDB_W-1:0]           vld_d, vld_q, wr_d, wr_q;
  logic [CDB_W*PRF_IDX_W-1:0] tag_d, tag_q;
  logic [CDB_W*DATA_W-1:0]    value_d, value_q;
  logic [CDB_W*ROB_IDX_W-1:0] rob_d, rob_q;

  // Stage 0: channel requests; the FIFO head takes priority over the bypassed input
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      in_ent[k].wr      = fu_wr_i[k];
      in_ent[k].tag     = fu_tag_i[k*PRF_IDX_W +: PRF_IDX_W];
      in_ent[k].value   = fu_value_i[k*DATA_W +: DATA_W];
      in_ent[k].rob_idx = fu_rob_idx_i[k*ROB_IDX_W +: ROB_IDX_W];
      nonempty[k]       = (cnt_q[k] != '0);
      rdy[k]            = (cnt_q[k] != CNT_W'(BUF_DEPTH));
      accept[k]         = fu_vld_i[k] & rdy[k] & ~flush_i;
      req[k]            = nonempty[k] | accept[k];
      cand[k]           = nonempty[k] ? buf_q[k][head_q[k]] : in_ent[k];
    end
  end

  assign fu_rdy_o = rdy;

  // Round-robin scan from rr_q; the n-th requester found is routed to port n
  always_comb begin
    int n;
    n    = 0;
    gnt  = '0;
    rr_d = rr_q;
    for (int p = 0; p < CDB_W; p++) port_oh[p] = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (!flush_i && req[k] && n < CDB_W && k == (int'(rr_q) + i) % NUM_FU) begin
          gnt[k] = 1'b1;
          for (int p = 0; p < CDB_W; p++) if (p == n) port_oh[p][k] = 1'b1;
          n    = n + 1;
          rr_d = RR_W'((k + 1) % NUM_FU);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      pop[k]  = gnt[k] & nonempty[k];
      push[k] = accept[k] & ~(gnt[k] & ~nonempty[k]);
    end
  end

  always_comb begin
    entry_t sel;
    vld_d   = '0;
    wr_d    = '0;
    tag_d   = '0;
    value_d = '0;
    rob_d   = '0;
    for (int p = 0; p < CDB_W; p++) begin
      sel = '0;
      for (int k = 0; k < NUM_FU; k++) if (port_oh[p][k]) sel = cand[k];
      vld_d[p]                          = |port_oh[p];
      wr_d[p]                           = sel.wr;
      tag_d[p*PRF_IDX_W +: PRF_IDX_W]   = sel.wr ? sel.tag : '0;
      value_d[p*DATA_W +: DATA_W]       = sel.value;
      rob_d[p*ROB_IDX_W +: ROB_IDX_W]   = sel.rob_idx;
    end
  end

  // Stage 1: FIFO bookkeeping and broadcast registers
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rr_q <= '0;
      for (int k = 0; k < NUM_FU; k++) begin
        head_q[k] <= '0;
        tail_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int k = 0; k < NUM_FU; k++) begin
        if (push[k]) tail_q[k] <= tail_q[k] + PTR_W'(1);
        if (pop[k])  head_q[k] <= head_q[k] + PTR_W'(1);
        if (push[k] && !pop[k])      cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        else if (!push[k] && pop[k]) cnt_q[k] <= cnt_q[k] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_FU; k++)
      if (push[k]) buf_q[k][tail_q[k]] <= in_ent[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      wr_q    <= '0;
      tag_q   <= '0;
      value_q <= '0;
      rob_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      wr_q    <= wr_d;
      tag_q   <= tag_d;
      value_q <= value_d;
      rob_q   <= rob_d;
    end
  end

  assign cdb_vld_o     = vld_q;
  assign cdb_wr_o      = wr_q;
  assign cdb_tag_o     = tag_q;
  assign cdb_value_o   = value_q;
  assign cdb_rob_idx_o = rob_q;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Bench for fu_wb_arbiter: directed scenarios plus randomized traffic against
// a queue-based reference model of the writeback arbiter.
module tb_fu_wb_arbiter;

  localparam int NUM_FU    = 4;
  localparam int CDB_W     = 2;
  localparam int BUF_DEPTH = 2;
  localparam int DATA_W    = 64;
  localparam int PRF_IDX_W = 6;
  localparam int ROB_IDX_W = 5;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        flush_i;
  logic [NUM_FU-1:0]           fu_vld;
  logic [NUM_FU-1:0]           fu_wr;
  logic [NUM_FU*PRF_IDX_W-1:0] fu_tag;
  logic [NUM_FU*DATA_W-1:0]    fu_value;
  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob;
  logic [NUM_FU-1:0]           fu_rdy;
  logic [CDB_W-1:0]            cdb_vld;
  logic [CDB_W-1:0]            cdb_wr;
  logic [CDB_W*PRF_IDX_W-1:0]  cdb_tag;
  logic [CDB_W*DATA_W-1:0]     cdb_value;
  logic [CDB_W*ROB_IDX_W-1:0]  cdb_rob;

  always #5 clk = ~clk;

  fu_wb_arbiter #(
    .NUM_FU(NUM_FU), .CDB_W(CDB_W), .BUF_DEPTH(BUF_DEPTH),
    .DATA_W(DATA_W), .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .fu_vld_i(fu_vld), .fu_wr_i(fu_wr), .fu_tag_i(fu_tag),
    .fu_value_i(fu_value), .fu_rob_idx_i(fu_rob), .fu_rdy_o(fu_rdy),
    .cdb_vld_o(cdb_vld), .cdb_wr_o(cdb_wr), .cdb_tag_o(cdb_tag),
    .cdb_value_o(cdb_value), .cdb_rob_idx_o(cdb_rob)
  );

  typedef struct packed {
    logic                 wr;
    logic [PRF_IDX_W-1:0] tag;
    logic [DATA_W-1:0]    value;
    logic [ROB_IDX_W-1:0] rob;
  } ment_t;

  ment_t                mq [NUM_FU][$];
  int                   rr_m;
  logic                 exp_vld [CDB_W];
  logic                 exp_wr  [CDB_W];
  logic [PRF_IDX_W-1:0] exp_tag [CDB_W];
  logic [DATA_W-1:0]    exp_val [CDB_W];
  logic [ROB_IDX_W-1:0] exp_rob [CDB_W];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NUM_FU-1:0] m_rdy();
    logic [NUM_FU-1:0] r;
    for (int k = 0; k < NUM_FU; k++) r[k] = (mq[k].size() < BUF_DEPTH);
    return r;
  endfunction

  // One clock edge in the model: enqueue accepted results, then hand the
  // oldest result of the first CDB_W non-empty channels (scan from rr_m) to the ports.
  task automatic model_step();
    ment_t e;
    int n, last, k;
    for (int p = 0; p < CDB_W; p++) begin
      exp_vld[p] = 0; exp_wr[p] = 0; exp_tag[p] = '0; exp_val[p] = '0; exp_rob[p] = '0;
    end
    if (rst || flush_i) begin
      for (int c = 0; c < NUM_FU; c++) mq[c].delete();
      rr_m = 0;
    end else begin
      for (int c = 0; c < NUM_FU; c++) begin
        if (fu_vld[c] && mq[c].size() < BUF_DEPTH) begin
          e.wr    = fu_wr[c];
          e.tag   = fu_tag[c*PRF_IDX_W +: PRF_IDX_W];
          e.value = fu_value[c*DATA_W +: DATA_W];
          e.rob   = fu_rob[c*ROB_IDX_W +: ROB_IDX_W];
          mq[c].push_back(e);
        end
      end
      n = 0;
      last = -1;
      for (int i = 0; i < NUM_FU; i++) begin
        k = (rr_m + i) % NUM_FU;
        if (n < CDB_W && mq[k].size() != 0) begin
          e = mq[k].pop_front();
          exp_vld[n] = 1'b1;
          exp_wr[n]  = e.wr;
          exp_tag[n] = e.wr ? e.tag : '0;
          exp_val[n] = e.value;
          exp_rob[n] = e.rob;
          n++;
          last = k;
        end
      end
      if (last >= 0) rr_m = (last + 1) % NUM_FU;
    end
  endtask

  task automatic compare();
    for (int p = 0; p < CDB_W; p++) begin
      chk($sformatf("vld%0d", p), 64'(cdb_vld[p]), 64'(exp_vld[p]));
      chk($sformatf("wr%0d", p), 64'(cdb_wr[p]), 64'(exp_wr[p]));
      chk($sformatf("tag%0d", p), 64'(cdb_tag[p*PRF_IDX_W +: PRF_IDX_W]), 64'(exp_tag[p]));
      chk($sformatf("value%0d", p), 64'(cdb_value[p*DATA_W +: DATA_W]), 64'(exp_val[p]));
      chk($sformatf("rob%0d", p), 64'(cdb_rob[p*ROB_IDX_W +: ROB_IDX_W]), 64'(exp_rob[p]));
    end
    chk("rdy", 64'(fu_rdy), 64'(m_rdy()));
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic clear_in();
    fu_vld = '0; fu_wr = '0; fu_tag = '0; fu_value = '0; fu_rob = '0;
  endtask

  // Presents a result only when the model says the channel is ready.
  task automatic set_in(input int k, input logic wr, input logic [PRF_IDX_W-1:0] tag,
                        input logic [DATA_W-1:0] value, input logic [ROB_IDX_W-1:0] rob);
    fu_vld[k] = m_rdy()[k];
    fu_wr[k]  = wr;
    fu_tag[k*PRF_IDX_W +: PRF_IDX_W] = tag;
    fu_value[k*DATA_W +: DATA_W]     = value;
    fu_rob[k*ROB_IDX_W +: ROB_IDX_W] = rob;
  endtask

  task automatic all_in(input int base);
    for (int k = 0; k < NUM_FU; k++)
      set_in(k, 1'b1, PRF_IDX_W'(base + k), DATA_W'(base * 16 + k), ROB_IDX_W'(base + k));
  endtask

  task automatic do_reset();
    rst = 1'b1; flush_i = 1'b0; clear_in();
    advance();
    rst = 1'b0;
  endtask

  initial begin
    int pct;
    rr_m = 0;
    rst = 1'b1; flush_i = 1'b0; clear_in();
    advance();
    advance();
    chk("reset_vld", 64'(cdb_vld), 64'(0));
    chk("reset_rdy", 64'(fu_rdy), 64'(4'hF));
    chk("reset_value", 64'(cdb_value), 64'(0));
    rst = 1'b0;

    // single result on ch1
    set_in(1, 1'b1, 6'd5, 64'h1234, 5'd3);
    advance();
    chk("single_vld", 64'(cdb_vld), 64'(2'b01));
    chk("single_tag", 64'(cdb_tag[5:0]), 64'(5));
    chk("single_value", 64'(cdb_value[63:0]), 64'h1234);
    chk("single_rob", 64'(cdb_rob[4:0]), 64'(3));
    clear_in();
    advance();
    chk("single_after", 64'(cdb_vld), 64'(0));

    // all four channels at once from rr=0
    do_reset();
    all_in(10);
    advance();
    chk("all_c1_p0", 64'(cdb_rob[4:0]), 64'(10));
    chk("all_c1_p1", 64'(cdb_rob[9:5]), 64'(11));
    clear_in();
    advance();
    chk("all_c2_p0", 64'(cdb_rob[4:0]), 64'(12));
    chk("all_c2_p1", 64'(cdb_rob[9:5]), 64'(13));
    clear_in();
    set_in(1, 1'b1, 6'd1, 64'd1, 5'd21);
    set_in(0, 1'b1, 6'd2, 64'd2, 5'd20);
    advance();
    chk("rr_wrap_p0", 64'(cdb_rob[4:0]), 64'(20));
    clear_in();

    // branch result: no register write
    set_in(2, 1'b0, 6'd9, 64'hBEEF, 5'd7);
    advance();
    chk("branch_vld", 64'(cdb_vld[0]), 64'(1));
    chk("branch_wr", 64'(cdb_wr[0]), 64'(0));
    chk("branch_tag", 64'(cdb_tag[5:0]), 64'(0));
    chk("branch_rob", 64'(cdb_rob[4:0]), 64'(7));
    clear_in();
    advance();

    // sustained traffic on every channel builds back-pressure
    do_reset();
    for (int c = 0; c < 3; c++) begin clear_in(); all_in(c * 4); advance(); end
    chk("bp_rdy3", 64'(fu_rdy), 64'(4'b0011));
    clear_in(); all_in(12); advance();
    chk("bp_rdy4", 64'(fu_rdy), 64'(4'b1100));

    // flush with results buffered and ch3 presenting
    clear_in(); all_in(20);
    set_in(3, 1'b1, 6'd33, 64'hDEAD, 5'd31);
    flush_i = 1'b1;
    advance();
    chk("flush_vld", 64'(cdb_vld), 64'(0));
    chk("flush_rdy", 64'(fu_rdy), 64'(4'hF));
    chk("flush_value", 64'(cdb_value), 64'(0));
    flush_i = 1'b0; clear_in();
    advance();
    chk("flush_drop", 64'(cdb_vld), 64'(0));

    // reset with full buffers and rr away from 0
    for (int c = 0; c < 3; c++) begin clear_in(); all_in(c * 4); advance(); end
    rst = 1'b1;
    advance();
    chk("rst_full_vld", 64'(cdb_vld), 64'(0));
    chk("rst_full_rdy", 64'(fu_rdy), 64'(4'hF));
    rst = 1'b0; clear_in();
    set_in(2, 1'b1, 6'd2, 64'd2, 5'd22);
    set_in(0, 1'b1, 6'd1, 64'd1, 5'd24);
    advance();
    chk("rst_first_p0", 64'(cdb_rob[4:0]), 64'(24));
    chk("rst_first_p1", 64'(cdb_rob[9:5]), 64'(22));

    // randomized traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      pct = ((c / 400) % 2 == 0) ? 85 : 35;
      rst = ($urandom_range(0, 199) == 0);
      flush_i = ($urandom_range(0, 59) == 0);
      clear_in();
      for (int k = 0; k < NUM_FU; k++)
        if ($urandom_range(0, 99) < pct)
          set_in(k, ($urandom_range(0, 3) != 0), PRF_IDX_W'($urandom_range(0, 63)),
                 {$urandom, $urandom}, ROB_IDX_W'($urandom_range(0, 31)));
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fu_wb_arbiter.md
# fu_wb_arbiter

Parametrised writeback/CDB arbiter between the execution units and the common data bus, PRF write port(s) and ROB completion. Each of NUM_FU unit result streams gets a small result buffer. Up to CDB_W results per cycle are broadcast under round-robin arbitration, so simultaneous completions are never dropped. Back-pressure is returned to each unit. A flush squashes all in-flight results on branch recovery.

## Interface
- NUM_FU, 4: number of unit result channels (2..8)
- CDB_W, 2: broadcast ports per cycle (1..NUM_FU)
- BUF_DEPTH, 2: result buffer entries per channel (power of 2, >=2)
- DATA_W, 64: result value width
- PRF_IDX_W, 6: physical register tag width
- ROB_IDX_W, 5: ROB index width
- clk  in  1  clock; reset rst, synchronous, active-high; clock clk
- rst  in  1  synchronous active-high reset
- flush_i  in  1  squash all buffered and incoming results
- fu_vld_i  in  NUM_FU  channel result valid
- fu_wr_i  in  NUM_FU  result writes a physical register (0 for branch/store)
- fu_tag_i  in  NUM_FU*PRF_IDX_W  destination tag per channel, channel k at bits [k*PRF_IDX_W +: PRF_IDX_W]
- fu_value_i  in  NUM_FU*DATA_W  result value per channel
- fu_rob_idx_i  in  NUM_FU*ROB_IDX_W  ROB index per channel
- fu_rdy_o  out  NUM_FU  channel can accept a result this cycle
- cdb_vld_o  out  CDB_W  broadcast port valid (drives ROB done)
- cdb_wr_o  out  CDB_W  PRF write enable / tag broadcast valid
- cdb_tag_o  out  CDB_W*PRF_IDX_W  broadcast tag
- cdb_value_o  out  CDB_W*DATA_W  broadcast value
- cdb_rob_idx_o  out  CDB_W*ROB_IDX_W  ROB index

## Operation
- Per channel: circular FIFO of BUF_DEPTH entries {wr, tag, value, rob_idx}, with head/tail pointers and count (0..BUF_DEPTH).
- fu_rdy_o[k] = (count[k] != BUF_DEPTH). It is a function of registered state only, with no path from grant. A full channel is not ready even if it pops this cycle.
- Accept on channel k when fu_vld_i[k] & fu_rdy_o[k] & !flush_i. fu_vld_i with rdy low is a protocol violation; the unit must hold the result.
- Request k = (count[k]!=0) | accept[k]. Candidate = FIFO head if non-empty, else the incoming result (bypass). At most one result per channel per cycle.
- Arbiter: scan channels starting at rr_ptr, wrapping modulo NUM_FU. Grant the first CDB_W requesters to ports 0..CDB_W-1 in scan order.
- rr_ptr advances to (last granted channel + 1) mod NUM_FU. It is unchanged if nothing was granted.
- Granted non-empty channel: pop head. Push the accepted input if present.
- Granted empty channel: the bypassed input is not written to the FIFO.
- Simultaneous push and pop: count unchanged.
- Output registers load the granted entries. Ungranted ports load vld=0, wr=0, tag=0, value=0, rob_idx=0.
- cdb_wr_o = vld & entry.wr. Entries with wr=0 still drive ROB completion, but their tag is forced to 0.
- flush_i: clears all counts and pointers. Output registers load all-zero next edge. rr_ptr resets to 0. Same-cycle inputs are dropped and no grant occurs. Output already registered during the flush cycle is still presented; the ROB masks it.

## Timing
- Reset: all counts, pointers and rr_ptr are 0. fu_rdy_o all 1. cdb_vld_o, cdb_wr_o, cdb_tag_o, cdb_value_o and cdb_rob_idx_o are all 0.
- Latency: a result presented in cycle c that is granted in cycle c appears on the cdb_* outputs in cycle c+1. Each buffered cycle adds 1.
- Throughput: CDB_W results/cycle aggregate, 1 result/cycle per channel.
- Wait bound: with all channels requesting, a result waits at most ceil(NUM_FU/CDB_W)-1 grant rounds behind other channels.
- Reset mid-operation overrides flush and all inputs.

## Test plan
- Single result, NUM_FU=4, CDB_W=2: ch1 vld, tag=5, value=0x1234, rob=3 in cycle c -> cdb_vld_o[0]=1, tag 5, value 0x1234, rob 3 in c+1. Outputs zero in c+2.
- All 4 channels valid for one cycle, rr_ptr=0 -> cycle c+1: ports carry ch0, ch1. Cycle c+2: ch2, ch3. rr_ptr returns to 0. No result lost.
- ch0 held valid for 4 consecutive cycles with CDB_W=1 and ch2 also valid -> grants alternate ch0, ch2, and ch0 reaches count 2. fu_rdy_o[0]=0 during the cycle in which count=2.
- Branch result with fu_wr_i=0, rob=7 -> cdb_vld_o=1, cdb_wr_o=0, tag 0, rob 7.
- Buffers partially full, then flush_i for 1 cycle while ch3 valid -> next cycle all cdb outputs 0. All fu_rdy_o=1. ch3 result never broadcast.
- rst asserted with full buffers -> next cycle outputs zero, fu_rdy_o all 1. First post-reset grant starts at ch0.
